trigger_conditioner: RTL and testbench

//  Upstream conditioner for the CPU top-level 'trigger' input. Takes a raw async push-button,

---
 rtl/trig_pkg.sv | 16 +
 rtl/sync_2ff.sv | 21 ++
 rtl/trigger_conditioner.sv | 104 ++++++++++
 tb/tb_trigger_conditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared types for the trigger conditioner: FSM state encoding used by the RTL and its bench.
package trig_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HOLD      = 3'd2,
        WAIT_REL  = 3'd3,
        DEB_REL   = 3'd4
    } trig_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Reusable two-flop synchroniser for a single asynchronous level, synchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/trigger_conditioner.sv
// Push-button conditioner: synchronise, debounce press/release, emit one fixed-length trigger pulse
// per accepted press, and keep a wrapping count of accepted presses.
module trigger_conditioner
    import trig_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_i,
    output logic       trigger_o,
    output logic       busy_o,
    output logic [7:0] press_count_o
);

    localparam int unsigned MAX_CYC   = max_u(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam int unsigned CNT_WIDTH = $clog2(MAX_CYC + 1);

    localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 btn_s;
    trig_state_t          state;
    trig_state_t          state_next;
    logic [CNT_WIDTH-1:0] timer;
    logic [CNT_WIDTH-1:0] timer_next;
    logic                 count_inc;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_i),
        .q_o (btn_s)
    );

    // Next-state logic; timer defaults to 0 so every state change clears it.
    always_comb begin
        state_next = IDLE;
        timer_next = '0;
        count_inc  = 1'b0;
        case (state)
            IDLE: begin
                state_next = btn_s ? DEB_PRESS : IDLE;
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (timer == DEB_LAST) begin
                    state_next = HOLD;
                    count_inc  = 1'b1;
                end else begin
                    state_next = DEB_PRESS;
                    timer_next = timer + CNT_ONE;
                end
            end
            HOLD: begin
                if (timer == HOLD_LAST) begin
                    state_next = WAIT_REL;
                end else begin
                    state_next = HOLD;
                    timer_next = timer + CNT_ONE;
                end
            end
            WAIT_REL: begin
                state_next = btn_s ? WAIT_REL : DEB_REL;
            end
            DEB_REL: begin
                if (btn_s) begin
                    state_next = WAIT_REL;
                end else if (timer == DEB_LAST) begin
                    state_next = IDLE;
                end else begin
                    state_next = DEB_REL;
                    timer_next = timer + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            timer         <= '0;
            trigger_o     <= 1'b0;
            busy_o        <= 1'b0;
            press_count_o <= 8'd0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            trigger_o <= (state_next == HOLD);
            busy_o    <= (state_next != IDLE);
            if (count_inc) begin
                press_count_o <= press_count_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Bench for trigger_conditioner: directed vector table, hand-written corner sequences, and random
// button activity checked against a run-length reference model.
module tb_trigger_conditioner;
    import trig_pkg::*;

    localparam int D = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_i;
    logic       trigger_o;
    logic       busy_o;
    logic [7:0] press_count_o;

    always #5 clk = ~clk;

    trigger_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_i         (btn_i),
        .trigger_o     (trigger_o),
        .busy_o        (busy_o),
        .press_count_o (press_count_o)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int hi_cycles = 0;
    logic prev_trig = 1'b0;

    // Reference model: two-sample delay line, then run lengths of high/low samples.
    logic m_h1, m_h2;
    bit   m_wait_press;
    int   m_hi_run, m_lo_run, m_pulse, m_count;

    task automatic model_edge(input logic b, input logic r);
        logic s;
        if (!r) begin
            m_h1 = 1'b0; m_h2 = 1'b0;
            m_wait_press = 1'b1;
            m_hi_run = 0; m_lo_run = 0; m_pulse = 0; m_count = 0;
        end else begin
            s = m_h2; m_h2 = m_h1; m_h1 = b;
            if (m_pulse > 0) begin
                m_pulse--;
            end else if (m_wait_press) begin
                if (s) begin
                    m_hi_run++;
                    if (m_hi_run == D + 1) begin
                        m_count = (m_count + 1) % 256;
                        m_pulse = H;
                        m_wait_press = 1'b0;
                        m_hi_run = 0;
                    end
                end else begin
                    m_hi_run = 0;
                end
            end else begin
                if (!s) begin
                    m_lo_run++;
                    if (m_lo_run == D + 1) begin
                        m_wait_press = 1'b1;
                        m_lo_run = 0;
                    end
                end else begin
                    m_lo_run = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it.
    task automatic tick(input logic b, input logic r);
        btn_i = b;
        rst   = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        if (trigger_o && !prev_trig) pulses++;
        if (trigger_o) hi_cycles++;
        prev_trig = trigger_o;
        check("model_trigger", int'(trigger_o), int'(m_pulse > 0));
        check("model_busy", int'(busy_o), int'(!m_wait_press || m_hi_run > 0));
        check("model_count", int'(press_count_o), m_count);
    endtask

    task automatic wait_trigger(input int budget);
        int n = 0;
        while (!trigger_o && n < budget) begin
            tick(1'b1, 1'b1);
            n++;
        end
        check("trigger_timeout", int'(trigger_o), 1);
    endtask

    typedef struct {
        logic       btn;
        logic       rst_n;
        logic       trig;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic b, input logic r, input logic t, input logic bs, input int c);
        vec_t v;
        v.btn = b; v.rst_n = r; v.trig = t; v.busy = bs; v.cnt = 8'(c);
        vq.push_back(v);
    endtask

    initial begin
        int p0;
        btn_i = 1'b0;
        rst   = 1'b0;

        // Reset with button held, clean press, hold, release, then a 4-cycle glitch.
        add(0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) add(1, 1, 1, 1, 1);
        add(1, 1, 0, 1, 1);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1);
        add(1, 1, 0, 0, 1);
        add(1, 1, 0, 0, 1);
        add(1, 1, 0, 1, 1);
        add(1, 1, 0, 1, 1);
        add(0, 1, 0, 1, 1);
        add(0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 1);

        foreach (vq[i]) begin
            tick(vq[i].btn, vq[i].rst_n);
            check($sformatf("vec%0d_trigger", i), int'(trigger_o), int'(vq[i].trig));
            check($sformatf("vec%0d_busy", i), int'(busy_o), int'(vq[i].busy));
            check($sformatf("vec%0d_count", i), int'(press_count_o), int'(vq[i].cnt));
        end
        check("state_idle_after_glitch", int'(dut.state), int'(IDLE));

        // Minimum accepted press: five high cycles, full-length pulse regardless.
        tick(1'b0, 1'b0);
        hi_cycles = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 25; i++) tick(1'b0, 1'b1);
        check("min_press_pulse_len", hi_cycles, H);
        check("min_press_count", int'(press_count_o), 1);
        check("min_press_idle", int'(busy_o), 0);

        // Held indefinitely: exactly one pulse, parked busy.
        tick(1'b0, 1'b0);
        p0 = pulses;
        for (int i = 0; i < 60; i++) tick(1'b1, 1'b1);
        check("held_one_pulse", pulses - p0, 1);
        check("held_busy", int'(busy_o), 1);

        // Release bounce after a clean press: no second pulse, IDLE after 5 stable lows + sync lag.
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b1);
            tick(1'b1, 1'b1);
            tick(1'b1, 1'b1);
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
        check("bounce_busy_before", int'(busy_o), 1);
        tick(1'b0, 1'b1);
        check("bounce_idle", int'(busy_o), 0);
        check("bounce_one_pulse", pulses - p0, 1);
        check("bounce_count", int'(press_count_o), 1);

        // Reset during the third HOLD cycle.
        wait_trigger(20);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("pre_reset_trigger", int'(trigger_o), 1);
        tick(1'b1, 1'b0);
        check("midhold_reset_trigger", int'(trigger_o), 0);
        check("midhold_reset_busy", int'(busy_o), 0);
        check("midhold_reset_count", int'(press_count_o), 0);
        check("midhold_reset_state", int'(dut.state), int'(IDLE));

        // Counter wrap over 257 press/release pairs.
        tick(1'b0, 1'b0);
        p0 = pulses;
        for (int p = 1; p <= 257; p++) begin
            for (int i = 0; i < 16; i++) tick(1'b1, 1'b1);
            for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
            if (p == 256) check("wrap_256", int'(press_count_o), 0);
        end
        check("wrap_257", int'(press_count_o), 1);
        check("wrap_pulses", pulses - p0, 257);

        // Random runs with occasional resets, checked by the model each cycle.
        for (int r = 0; r < 400; r++) begin
            int len;
            logic b;
            len = int'($urandom_range(1, 12));
            b   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) tick(b, 1'b0);
            for (int i = 0; i < len; i++) tick(b, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
